// File: rtl/wish_pkg.sv
// Shared definitions for the Wishbone pack/unpack family: tag bit indices and lane ordering.
package wish_pkg;

  localparam int unsigned TGC_FIRST = 0;
  localparam int unsigned TGC_LAST  = 1;

  // Lane driven on beat k of an n-lane word; big-endian sends the MSB lane first.
  function automatic int unsigned lane_sel(input int unsigned k, input logic le,
                                           input int unsigned n);
    return le ? k : (n - 1 - k);
  endfunction

endpackage

// File: rtl/wish_word_buf.sv
// Two-entry word buffer: an active word being drained plus one prefetched word behind it.
module wish_word_buf
  import wish_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 3,
  parameter int unsigned TGC_WIDTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [WORD_WIDTH-1:0] push_word_i,
  input  logic [CNT_WIDTH-1:0]  push_cnt_i,
  input  logic [TGC_WIDTH-1:0]  push_tgc_i,
  input  logic                  pop_i,
  output logic                  act_valid_o,
  output logic [WORD_WIDTH-1:0] act_word_o,
  output logic [CNT_WIDTH-1:0]  act_cnt_o,
  output logic [TGC_WIDTH-1:0]  act_tgc_o,
  output logic                  pf_valid_o
);

  logic                  act_v_q, act_v_d, pf_v_q, pf_v_d;
  logic [WORD_WIDTH-1:0] act_word_q, act_word_d, pf_word_q, pf_word_d;
  logic [CNT_WIDTH-1:0]  act_cnt_q, act_cnt_d, pf_cnt_q, pf_cnt_d;
  logic [TGC_WIDTH-1:0]  act_tgc_q, act_tgc_d, pf_tgc_q, pf_tgc_d;

  // Next-state: push goes to active if it is empty or popping, else to prefetch.
  // The caller never pushes while prefetch is full, so a push cannot collide with a refill.
  always_comb begin
    act_v_d    = act_v_q;
    act_word_d = act_word_q;
    act_cnt_d  = act_cnt_q;
    act_tgc_d  = act_tgc_q;
    pf_v_d     = pf_v_q;
    pf_word_d  = pf_word_q;
    pf_cnt_d   = pf_cnt_q;
    pf_tgc_d   = pf_tgc_q;
    if (act_v_q && !pop_i) begin
      if (push_i) begin
        pf_v_d    = 1'b1;
        pf_word_d = push_word_i;
        pf_cnt_d  = push_cnt_i;
        pf_tgc_d  = push_tgc_i;
      end
    end else if (pf_v_q) begin
      act_v_d    = 1'b1;
      act_word_d = pf_word_q;
      act_cnt_d  = pf_cnt_q;
      act_tgc_d  = pf_tgc_q;
      pf_v_d     = 1'b0;
    end else begin
      act_v_d = push_i;
      if (push_i) begin
        act_word_d = push_word_i;
        act_cnt_d  = push_cnt_i;
        act_tgc_d  = push_tgc_i;
      end
    end
  end

  // Buffer registers; reset discards both entries.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      act_v_q    <= 1'b0;
      act_word_q <= '0;
      act_cnt_q  <= '0;
      act_tgc_q  <= '0;
      pf_v_q     <= 1'b0;
      pf_word_q  <= '0;
      pf_cnt_q   <= '0;
      pf_tgc_q   <= '0;
    end else begin
      act_v_q    <= act_v_d;
      act_word_q <= act_word_d;
      act_cnt_q  <= act_cnt_d;
      act_tgc_q  <= act_tgc_d;
      pf_v_q     <= pf_v_d;
      pf_word_q  <= pf_word_d;
      pf_cnt_q   <= pf_cnt_d;
      pf_tgc_q   <= pf_tgc_d;
    end
  end

  assign act_valid_o = act_v_q;
  assign act_word_o  = act_word_q;
  assign act_cnt_o   = act_cnt_q;
  assign act_tgc_o   = act_tgc_q;
  assign pf_valid_o  = pf_v_q;

endmodule

// File: rtl/wish_unpack_var.sv
// Streaming Wishbone width down-converter with per-word lane count and one-word prefetch.
module wish_unpack_var
  import wish_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH    = 8,
  parameter int unsigned  NUM_PACK      = 4,
  parameter int unsigned  TGC_WIDTH     = 2,
  parameter int unsigned  LITTLE_ENDIAN = 0,
  localparam int unsigned CNT_WIDTH     = $clog2(NUM_PACK + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           s_stb_i,
  input  logic                           s_cyc_i,
  input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
  input  logic [CNT_WIDTH-1:0]           s_cnt_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           s_stall_o,
  output logic                           s_ack_o,
  output logic                           d_stb_o,
  output logic                           d_cyc_o,
  output logic [DATA_WIDTH-1:0]          d_dat_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o,
  input  logic                           d_ack_i
);

  localparam int unsigned WORD_WIDTH = DATA_WIDTH * NUM_PACK;

  logic                  stall, accept, last_beat, beat_done, pop;
  logic [CNT_WIDTH-1:0]  cnt_norm, beat_q, beat_d;
  logic                  ack_q, ack_d;
  logic                  act_valid, pf_valid;
  logic [WORD_WIDTH-1:0] act_word;
  logic [CNT_WIDTH-1:0]  act_cnt;
  logic [TGC_WIDTH-1:0]  act_tgc;
  logic [DATA_WIDTH-1:0] beat_dat;
  logic [TGC_WIDTH-1:0]  beat_tgc;
  int unsigned           lane;

  // Source side: stall while prefetch is full (and during reset); out-of-range counts mean full.
  always_comb begin
    stall    = ~rst_n_i | pf_valid;
    accept   = s_stb_i & s_cyc_i & ~stall;
    cnt_norm = s_cnt_i;
    if (s_cnt_i == '0 || s_cnt_i > CNT_WIDTH'(NUM_PACK)) begin
      cnt_norm = CNT_WIDTH'(NUM_PACK);
    end
  end

  // Lane counter: advances on each completed beat, wraps after the word's last valid beat.
  always_comb begin
    last_beat = (beat_q == act_cnt - CNT_WIDTH'(1));
    beat_done = act_valid & d_ack_i;
    pop       = beat_done & last_beat;
    ack_d     = accept;
    beat_d    = beat_q;
    if (pop) begin
      beat_d = '0;
    end else if (beat_done) begin
      beat_d = beat_q + CNT_WIDTH'(1);
    end
  end

  // Beat mux and tag shaping; outputs are forced to zero while no word is active.
  always_comb begin
    lane     = lane_sel(32'(beat_q), LITTLE_ENDIAN != 0, NUM_PACK);
    beat_dat = '0;
    for (int unsigned i = 0; i < NUM_PACK; i++) begin
      if (lane == i) beat_dat = act_word[i*DATA_WIDTH +: DATA_WIDTH];
    end
    beat_tgc            = act_tgc;
    beat_tgc[TGC_FIRST] = act_tgc[TGC_FIRST] & (beat_q == '0);
    beat_tgc[TGC_LAST]  = act_tgc[TGC_LAST] & last_beat;
    d_stb_o             = act_valid;
    d_cyc_o             = act_valid;
    d_dat_o             = act_valid ? beat_dat : '0;
    d_tgc_o             = act_valid ? beat_tgc : '0;
  end

  // Lane index and registered source acknowledge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      beat_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      ack_q  <= ack_d;
    end
  end

  assign s_stall_o = stall;
  assign s_ack_o   = ack_q;

  wish_word_buf #(
    .WORD_WIDTH(WORD_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .TGC_WIDTH (TGC_WIDTH)
  ) u_buf (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (accept),
    .push_word_i(s_dat_i),
    .push_cnt_i (cnt_norm),
    .push_tgc_i (s_tgc_i),
    .pop_i      (pop),
    .act_valid_o(act_valid),
    .act_word_o (act_word),
    .act_cnt_o  (act_cnt),
    .act_tgc_o  (act_tgc),
    .pf_valid_o (pf_valid)
  );

endmodule

// File: tb/tb_wish_unpack_var.sv
// Directed bench: a big-endian and a little-endian instance share one stimulus stream.
module tb_wish_unpack_var;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_stb, s_cyc, d_ack;
  logic [31:0] s_dat;
  logic [2:0]  s_cnt;
  logic [1:0]  s_tgc;

  logic       be_stall, be_ack, be_stb, be_cyc;
  logic [7:0] be_dat;
  logic [1:0] be_tgc;
  logic       le_stall, le_ack, le_stb, le_cyc;
  logic [7:0] le_dat;
  logic [1:0] le_tgc;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] wv[3];
  logic [2:0]  cv[3];

  wish_unpack_var #(.LITTLE_ENDIAN(0)) u_be (
    .clk_i(clk), .rst_n_i(rst_n), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_dat_i(s_dat),
    .s_cnt_i(s_cnt), .s_tgc_i(s_tgc), .s_stall_o(be_stall), .s_ack_o(be_ack),
    .d_stb_o(be_stb), .d_cyc_o(be_cyc), .d_dat_o(be_dat), .d_tgc_o(be_tgc), .d_ack_i(d_ack)
  );

  wish_unpack_var #(.LITTLE_ENDIAN(1)) u_le (
    .clk_i(clk), .rst_n_i(rst_n), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_dat_i(s_dat),
    .s_cnt_i(s_cnt), .s_tgc_i(s_tgc), .s_stall_o(le_stall), .s_ack_o(le_ack),
    .d_stb_o(le_stb), .d_cyc_o(le_cyc), .d_dat_o(le_dat), .d_tgc_o(le_tgc), .d_ack_i(d_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic stb, input logic [31:0] dat, input logic [2:0] cnt,
                       input logic [1:0] tgc);
    s_stb = stb;
    s_cyc = stb;
    s_dat = dat;
    s_cnt = cnt;
    s_tgc = tgc;
  endtask

  // Check one beat on both instances.
  task automatic beat(input string tag, input logic [7:0] bd, input logic [1:0] bt,
                      input logic [7:0] ld, input logic [1:0] lt);
    chk({tag, " be_stb"}, 32'(be_stb & be_cyc), 32'd1);
    chk({tag, " be_dat"}, 32'(be_dat), 32'(bd));
    chk({tag, " be_tgc"}, 32'(be_tgc), 32'(bt));
    chk({tag, " le_stb"}, 32'(le_stb & le_cyc), 32'd1);
    chk({tag, " le_dat"}, 32'(le_dat), 32'(ld));
    chk({tag, " le_tgc"}, 32'(le_tgc), 32'(lt));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " be_stb"}, 32'(be_stb), 32'd0);
    chk({tag, " le_stb"}, 32'(le_stb), 32'd0);
  endtask

  // Source pushes nw full-length words whenever not stalled; sink drops ack for lo_n cycles.
  // Output must be one continuous run of 4*nw beats starting the cycle after the first accept.
  task automatic stream(input string tag, input int nw, input int lo_s, input int lo_n);
    int          src = 0;
    int          b = 0;
    int          total = 4 * nw;
    logic        st;
    logic [31:0] be_w, le_w;
    for (int cyc = 0; cyc < total + lo_n + 2; cyc++) begin
      d_ack = !(cyc >= lo_s && cyc < lo_s + lo_n);
      if (src < nw) drive(1'b1, wv[src], cv[src], 2'b11);
      else drive(1'b0, 32'h0, 3'd0, 2'b00);
      st = be_stall;
      if (lo_n > 0 && cyc == lo_s + 2) chk({tag, " stall_full"}, 32'(be_stall), 32'd1);
      if (cyc >= 1 && b < total) begin
        be_w = wv[b/4] >> (8 * (3 - (b % 4)));
        le_w = wv[b/4] >> (8 * (b % 4));
        beat($sformatf("%s b%0d", tag, b), be_w[7:0], {(b % 4) == 3, (b % 4) == 0},
             le_w[7:0], {(b % 4) == 3, (b % 4) == 0});
      end else if (cyc >= 1) begin
        idle_chk({tag, " drained"});
      end
      tick();
      if (src < nw && !st) src++;
      if (cyc >= 1 && b < total && d_ack) b++;
    end
    chk({tag, " words_accepted"}, 32'(src), 32'(nw));
    d_ack = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    d_ack = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 2'b00);
    tick();
    tick();
    // Reset state
    chk("rst be_stall", 32'(be_stall), 32'd1);
    chk("rst le_stall", 32'(le_stall), 32'd1);
    chk("rst be_ack", 32'(be_ack), 32'd0);
    chk("rst be_stb", 32'(be_stb | be_cyc), 32'd0);
    chk("rst be_dat", 32'(be_dat), 32'd0);
    chk("rst be_tgc", 32'(be_tgc), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel be_stall", 32'(be_stall), 32'd0);

    // Full word then partial word, both lane orders
    drive(1'b1, 32'h11223344, 3'd4, 2'b11);
    tick();
    drive(1'b1, 32'hAABBCCDD, 3'd2, 2'b10);
    chk("t1 ack0", 32'(be_ack), 32'd1);
    beat("t1 k0", 8'h11, 2'b01, 8'h44, 2'b01);
    tick();
    drive(1'b0, 32'h0, 3'd0, 2'b00);
    chk("t1 ack1", 32'(be_ack), 32'd1);
    beat("t1 k1", 8'h22, 2'b00, 8'h33, 2'b00);
    tick();
    chk("t1 ack_off", 32'(be_ack), 32'd0);
    beat("t1 k2", 8'h33, 2'b00, 8'h22, 2'b00);
    tick();
    beat("t1 k3", 8'h44, 2'b10, 8'h11, 2'b10);
    tick();
    beat("t2 k0", 8'hAA, 2'b00, 8'hDD, 2'b00);
    tick();
    beat("t2 k1", 8'hBB, 2'b10, 8'hCC, 2'b10);
    tick();
    idle_chk("t2 end");
    chk("t2 stall", 32'(be_stall), 32'd0);
    tick();

    // Back-to-back full words at full rate
    wv[0] = 32'h01020304; wv[1] = 32'h05060708; wv[2] = 32'h090A0B0C;
    cv[0] = 3'd4; cv[1] = 3'd4; cv[2] = 3'd4;
    stream("t3", 3, 0, 0);
    tick();

    // Sink back-pressure mid-word
    wv[0] = 32'hA1A2A3A4; wv[1] = 32'hB1B2B3B4; wv[2] = 32'hC1C2C3C4;
    stream("t4", 3, 3, 6);
    tick();

    // Out-of-range lane counts mean a full word
    wv[0] = 32'h5A6B7C8D; wv[1] = 32'h1F2E3D4C;
    cv[0] = 3'd0; cv[1] = 3'd7;
    stream("t5", 2, 0, 0);
    tick();

    // Reset in the middle of a word with a prefetched word behind it
    drive(1'b1, 32'h99887766, 3'd4, 2'b11);
    tick();
    drive(1'b1, 32'h55443322, 3'd4, 2'b11);
    beat("t6 k0", 8'h99, 2'b01, 8'h66, 2'b01);
    tick();
    drive(1'b0, 32'h0, 3'd0, 2'b00);
    beat("t6 k1", 8'h88, 2'b00, 8'h77, 2'b00);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6 async stb", 32'(be_stb | le_stb), 32'd0);
    chk("t6 async dat", 32'(be_dat), 32'd0);
    chk("t6 async tgc", 32'(be_tgc), 32'd0);
    chk("t6 async ack", 32'(be_ack), 32'd0);
    chk("t6 async stall", 32'(be_stall), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_chk($sformatf("t6 post%0d", i));
      chk($sformatf("t6 post%0d ack", i), 32'(be_ack), 32'd0);
    end
    drive(1'b1, 32'h01020304, 3'd1, 2'b11);
    tick();
    drive(1'b0, 32'h0, 3'd0, 2'b00);
    chk("t6 new ack", 32'(be_ack), 32'd1);
    beat("t6 new k0", 8'h01, 2'b11, 8'h04, 2'b11);
    tick();
    idle_chk("t6 new end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
